// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus shared by the fetch stage and instruction memory.
//   master (fetch stage): drives Imem_req_o / Imem_addr_o, receives grant and in-order responses.
//   slave  (memory)     : receives requests, drives Imem_gnt_i / Imem_rvalid_i / Imem_rdata_i.
// A request handshakes when Imem_req_o & Imem_gnt_i are both high at a rising clock edge.
// Responses arrive strictly in request order, at least one cycle after the grant.
interface if_stage_if;
  logic        Imem_req_o;
  logic [31:0] Imem_addr_o;
  logic        Imem_gnt_i;
  logic        Imem_rvalid_i;
  logic [31:0] Imem_rdata_i;

  modport master (
    output Imem_req_o,
    output Imem_addr_o,
    input  Imem_gnt_i,
    input  Imem_rvalid_i,
    input  Imem_rdata_i
  );

  modport slave (
    input  Imem_req_o,
    input  Imem_addr_o,
    output Imem_gnt_i,
    output Imem_rvalid_i,
    output Imem_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction Fetch stage.
// Owns the PC, issues in-order requests on the imem bus, buffers responses in a small FIFO and
// presents one instruction per cycle (or a bubble) to decode. Decode jumps and EX branches
// redirect the PC; responses still in flight at a redirect are counted and dropped on arrival.
//
// Ports:
//   Clk, Reset            clock (rising edge), asynchronous active-high reset
//   imem                  if_stage_if.master: Imem_req_o/Imem_addr_o out, gnt/rvalid/rdata in
//   Stall_data_hazard     decode stalled: hold all outputs
//   Inst_jump             decode holds JAL/JALR, target on Src_jump_target_i
//   Branch_taken_i        EX taken branch, target on Src_branch_target_i (wins over jump)
//   Instruction           instruction to decode (NOP_INST when bubble)
//   Src_pc_o              PC of Instruction
//   IF_tracker            8-bit sequence tag, increments per delivered instruction
//   Inst_valid_o          1 = real instruction, 0 = bubble
//   Perf_fetch_o          delivered instruction count
//   Perf_flush_o          redirect count
//
// Configuration macro: IF_PERF_CNT_EN. When defined, Perf_fetch_o/Perf_flush_o are 32-bit
// wrapping counters; otherwise both ports are tied to zero and no counter flops exist.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic              Clk,
  input  logic              Reset,
  if_stage_if.master        imem,
  input  logic              Stall_data_hazard,
  input  logic              Inst_jump,
  input  logic [31:0]       Src_jump_target_i,
  input  logic              Branch_taken_i,
  input  logic [31:0]       Src_branch_target_i,
  output logic [31:0]       Instruction,
  output logic [31:0]       Src_pc_o,
  output logic [7:0]        IF_tracker,
  output logic              Inst_valid_o,
  output logic [31:0]       Perf_fetch_o,
  output logic [31:0]       Perf_flush_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // State
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] tag_wr_q, tag_rd_q;
  logic [PW-1:0] f_wr_q, f_rd_q, f_wr_d, f_rd_d;
  logic [31:0]   tag_mem  [FIFO_DEPTH];
  logic [31:0]   fpc_mem  [FIFO_DEPTH];
  logic [31:0]   fdat_mem [FIFO_DEPTH];

  logic [31:0]   inst_q, inst_d;
  logic [31:0]   src_pc_q, src_pc_d;
  logic [7:0]    tracker_q, tracker_d;
  logic          valid_q, valid_d;

  // Control
  logic          redir;
  logic [31:0]   redir_target;
  logic [CW:0]   occupancy;
  logic          req;
  logic          hs;
  logic          rsp;
  logic          push;
  logic          pop;

  always_comb begin
    redir        = Branch_taken_i | (Inst_jump & ~Stall_data_hazard);
    redir_target = Branch_taken_i ? Src_branch_target_i : Src_jump_target_i;
    // Outstanding plus buffered must stay within FIFO_DEPTH so every response has a slot.
    occupancy    = {1'b0, outst_q} + {1'b0, fcnt_q};
    req          = ~Reset & ~redir & (occupancy < (CW + 1)'(FIFO_DEPTH));
    hs           = req & imem.Imem_gnt_i;
    rsp          = imem.Imem_rvalid_i;
    push         = rsp & (drop_q == '0) & ~redir;
    // Pop only from entries pushed in an earlier cycle (no same-cycle bypass).
    pop          = ~redir & ~Stall_data_hazard & (fcnt_q != '0);
  end

  assign imem.Imem_req_o  = req;
  assign imem.Imem_addr_o = pc_q;

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + CW'(hs) - CW'(rsp);
    drop_d  = drop_q;
    fcnt_d  = fcnt_q;
    f_wr_d  = f_wr_q;
    f_rd_d  = f_rd_q;

    if (redir) begin
      pc_d   = redir_target;
      // Everything still in flight after this cycle belongs to the wrong path.
      drop_d = outst_q - CW'(rsp);
      fcnt_d = '0;
      f_wr_d = '0;
      f_rd_d = '0;
    end else begin
      if (hs) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
      if (push) begin
        f_wr_d = ptr_inc(f_wr_q);
      end
      if (pop) begin
        f_rd_d = ptr_inc(f_rd_q);
      end
    end
  end

  always_comb begin
    inst_d    = inst_q;
    src_pc_d  = src_pc_q;
    tracker_d = tracker_q;
    valid_d   = valid_q;
    if (redir) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!Stall_data_hazard) begin
      if (pop) begin
        inst_d    = fdat_mem[f_rd_q];
        src_pc_d  = fpc_mem[f_rd_q];
        tracker_d = tracker_q + 8'd1;
        valid_d   = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      fcnt_q    <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      f_wr_q    <= '0;
      f_rd_q    <= '0;
      inst_q    <= NOP_INST;
      src_pc_q  <= '0;
      tracker_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      fcnt_q    <= fcnt_d;
      f_wr_q    <= f_wr_d;
      f_rd_q    <= f_rd_d;
      inst_q    <= inst_d;
      src_pc_q  <= src_pc_d;
      tracker_q <= tracker_d;
      valid_q   <= valid_d;
      // The PC tag queue tracks every in-flight request, including ones marked for dropping,
      // so it is never flushed by a redirect.
      if (hs) begin
        tag_wr_q <= ptr_inc(tag_wr_q);
      end
      if (rsp) begin
        tag_rd_q <= ptr_inc(tag_rd_q);
      end
    end
  end

  // Storage arrays carry no reset; pointers and counts define what is live.
  always_ff @(posedge Clk) begin
    if (hs) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (push) begin
      fpc_mem[f_wr_q]  <= tag_mem[tag_rd_q];
      fdat_mem[f_wr_q] <= imem.Imem_rdata_i;
    end
  end

  assign Instruction  = inst_q;
  assign Src_pc_o     = src_pc_q;
  assign IF_tracker   = tracker_q;
  assign Inst_valid_o = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pop) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (redir) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign Perf_fetch_o = perf_fetch_q;
  assign Perf_flush_o = perf_flush_q;
`else
  assign Perf_fetch_o = 32'd0;
  assign Perf_flush_o = 32'd0;
`endif

endmodule
